// File: rtl/matrix_row_scanner_if.sv
// Code-offer handshake between a 2-of-5 digit source and the row scanner.
// The source drives code_in/code_valid and holds them stable until code_ready.
interface matrix_row_scanner_if;
  logic [4:0] code_in;
  logic       code_valid;
  logic       code_ready;

  modport master (
    output code_in,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output code_ready
  );
endinterface

// File: rtl/matrix_row_scanner.sv
// Row scanner feeding the 7-row line decoder: takes 2-of-5 digits, blanks for one
// row slot, then scans L1..L7 with DIV cycles per row.
//
// state | meaning
// IDLE  | no digit shown yet, row_sel blank, accepting codes
// SCAN  | rows L1..L7 cycling every DIV cycles, accepting codes
// BLANK | row_sel blank for DIV cycles before the new digit appears, not accepting
module matrix_row_scanner #(
  parameter int DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_row_scanner_if.slave  code_bus,
  output logic [2:0]           row_sel,
  output logic [3:0]           digit,
  output logic                 digit_valid,
  output logic                 code_err,
  output logic                 frame_start
);

  localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  LAST      = PW'(DIV - 1);
  localparam logic [PW-1:0]  ONE       = PW'(1);
  localparam logic [2:0]     ROW_BLANK = 3'b111;
  localparam logic [2:0]     ROW_L1    = 3'b110;
  localparam logic [2:0]     ROW_L7    = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [2:0]    row_nxt;
  logic [3:0]    digit_nxt;
  logic [3:0]    pending, pending_nxt;
  logic          dv_nxt;
  logic          err_nxt;
  logic          fs_nxt;
  logic          ready;
  logic          xfer;
  logic [4:0]    dec;

  // Returns {valid, digit}; the ten listed codes are exactly the two-hot patterns,
  // so anything else is an invalid code.
  function automatic logic [4:0] decode_2of5(input logic [4:0] c);
    logic [4:0] r;
    case (c)
      5'b00011: r = {1'b1, 4'd1};
      5'b00101: r = {1'b1, 4'd2};
      5'b00110: r = {1'b1, 4'd3};
      5'b01001: r = {1'b1, 4'd4};
      5'b01010: r = {1'b1, 4'd5};
      5'b01100: r = {1'b1, 4'd6};
      5'b10001: r = {1'b1, 4'd7};
      5'b10010: r = {1'b1, 4'd8};
      5'b10100: r = {1'b1, 4'd9};
      5'b11000: r = {1'b1, 4'd0};
      default:  r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign ready               = (state != BLANK);
  assign code_bus.code_ready = ready;
  assign xfer                = code_bus.code_valid && ready;
  assign dec                 = decode_2of5(code_bus.code_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      row_sel     <= ROW_BLANK;
      digit       <= 4'd0;
      pending     <= 4'd0;
      digit_valid <= 1'b0;
      code_err    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      row_sel     <= row_nxt;
      digit       <= digit_nxt;
      pending     <= pending_nxt;
      digit_valid <= dv_nxt;
      code_err    <= err_nxt;
      frame_start <= fs_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    row_nxt     = row_sel;
    digit_nxt   = digit;
    pending_nxt = pending;
    dv_nxt      = digit_valid;
    err_nxt     = code_err;
    fs_nxt      = 1'b0;

    case (state)
      SCAN: begin
        if (presc == LAST) begin
          presc_nxt = '0;
          // L7 (000) wraps to L1 (110), skipping the blank code
          if (row_sel == ROW_L7) begin
            row_nxt = ROW_L1;
            fs_nxt  = 1'b1;
          end else begin
            row_nxt = row_sel - 3'd1;
          end
        end else begin
          presc_nxt = presc + ONE;
        end
      end
      BLANK: begin
        if (presc == LAST) begin
          state_nxt = SCAN;
          presc_nxt = '0;
          row_nxt   = ROW_L1;
          fs_nxt    = 1'b1;
          digit_nxt = pending;
          dv_nxt    = 1'b1;
        end else begin
          presc_nxt = presc + ONE;
        end
      end
      default: begin
        row_nxt = ROW_BLANK;
      end
    endcase

    // An accepted valid code aborts whatever frame is running.
    if (xfer) begin
      if (dec[4]) begin
        pending_nxt = dec[3:0];
        err_nxt     = 1'b0;
        state_nxt   = BLANK;
        presc_nxt   = '0;
        row_nxt     = ROW_BLANK;
        fs_nxt      = 1'b0;
      end else begin
        err_nxt     = 1'b1;
      end
    end
  end

endmodule

// File: doc/matrix_row_scanner.md
Name: matrix_row_scanner

Overview:
- Sequential stage directly upstream of the 7-row line decoder (3-bit select A,B,C -> one-hot L1..L7).
- Accepts a 2-of-5 coded digit over a valid/ready handshake, validates and decodes it, and drives the 3-bit row select that scans L1..L7 at a fixed slot rate.
- Holds the decoded digit for the downstream font/column stage.
- Row select 3'b111 is the blank code: no L line active.

Parameters:
- DIV, 1000, clock cycles per row slot; legal range DIV >= 1; prescaler width = clog2(DIV), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low; single clock domain.
- code_in  in  5  2-of-5 code, bit weights [4:0] = 7,4,2,1,0.
- code_valid  in  1  code_in valid.
- code_ready  out  1  block can accept a code.
- row_sel  out  3  {A,B,C} to row decoder, A = MSB.
- digit  out  4  decoded digit 0..9 currently displayed.
- digit_valid  out  1  digit holds a valid decoded value.
- code_err  out  1  last offered code was invalid (sticky).
- frame_start  out  1  one-cycle pulse when row_sel becomes 3'b110 (row L1).

Behaviour:
- Reset values (immediate on rst_n low, any state):
  - row_sel = 3'b111, digit = 0, digit_valid = 0, code_err = 0, code_ready = 1, frame_start = 0.
  - Prescaler = 0, state = IDLE.
- States:
  - IDLE: row_sel = 111, code_ready = 1.
  - SCAN: rows cycling, code_ready = 1.
  - BLANK: row_sel = 111 for exactly DIV cycles, code_ready = 0.
- Transfer occurs on a rising edge with code_valid && code_ready.
- Validation: the code is valid iff exactly two bits of code_in are 1.
- Decode table:
  - 00011=1, 00101=2, 00110=3, 01001=4, 01010=5
  - 01100=6, 10001=7, 10010=8, 10100=9, 11000=0
- Valid transfer in IDLE or SCAN:
  - Decoded value goes to a pending register; code_err clears.
  - Next cycle: state = BLANK, row_sel = 111, prescaler = 0.
  - A frame in progress is aborted.
- Invalid transfer:
  - code_err = 1 next cycle, held until the next valid transfer.
  - State, digit, row_sel and prescaler are unaffected; code_ready stays 1.
- BLANK exit, after DIV cycles:
  - digit = pending, digit_valid = 1, state = SCAN.
  - row_sel = 110 and frame_start = 1 in the same cycle.
- SCAN timing:
  - Prescaler counts 0..DIV-1; row advances on the cycle following prescaler = DIV-1.
  - Sequence: 110 (L1) -> 101 -> 100 -> 011 -> 010 -> 001 -> 000 (L7) -> 110, wrapping.
  - Frame period = 7*DIV cycles.
  - frame_start pulses for 1 cycle on each entry to 110.
- row_sel never takes 111 while in SCAN.
- Only one L line is active at any time.
- row_sel is registered, glitch-free and changes only on clock edges.
- Latency:
  - Accepted valid code -> row_sel = 111 after 1 cycle.
  - New digit is visible (L1 row) after 1 + DIV cycles.
- DIV = 1: row advances every cycle; BLANK lasts 1 cycle.
- code_valid while code_ready = 0: no transfer. The source holds code_in/code_valid stable until ready.
- digit_valid stays 1 once set, until reset.

Test Plan:
- Reset with DIV=4: assert rst_n=0 mid-SCAN -> row_sel=111, digit_valid=0, code_ready=1 in the same cycle without a clock edge; all outputs hold at reset values for 10 cycles after release with code_valid=0.
- Offer 00110 in IDLE -> row_sel=111 for cycles 1..4; at cycle 5 digit=3, digit_valid=1, row_sel=110, frame_start=1; then 101,100,011,010,001,000 every 4 cycles and back to 110 with frame_start at cycle 33.
- Offer the 10 codes in sequence, waiting for code_ready each time -> digit = 1,2,3,4,5,6,7,8,9,0; code_err stays 0.
- Offer 00111, then 00000, then 11111 during SCAN -> code_err=1 after the first; digit and row sequence are undisturbed; a following valid 11000 clears code_err and shows digit=0 after a BLANK.
- Offer 10100 while row_sel=011 -> frame aborts, row_sel=111 next cycle, code_ready=0 during BLANK; code_valid held high during BLANK is not consumed; then digit=9 from row 110.
- DIV=1: valid 01001 -> 1 blank cycle, then row_sel changes every cycle over 7 distinct codes; frame_start every 7 cycles.
